// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Brief    : Shared types and constants for the floor request scheduler.
// Revision : 1.0
// ============================================================================
package elevator_pkg;

    localparam int   c_DEF_NUM_FLOORS = 10;
    localparam int   c_DEF_FLOOR_W    = 4;
    localparam int   c_FLOOR_CODE_W   = 5;

    localparam logic c_DIR_UP   = 1'b1;
    localparam logic c_DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/call_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : call_sync_edge
// Brief    : 2-FF synchroniser plus rising-edge detector for floor-call inputs.
// Revision : 1.0
// ============================================================================
module call_sync_edge
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = c_DEF_NUM_FLOORS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    output logic [NUM_FLOORS-1:0] set
);

    logic [NUM_FLOORS-1:0] r_sync1;
    logic [NUM_FLOORS-1:0] r_sync2;
    logic [NUM_FLOORS-1:0] r_sync3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= call_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // A held switch yields a single one-cycle pulse.
    assign set = r_sync2 & ~r_sync3;

endmodule
`default_nettype wire

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : floor_request_scheduler
// Brief    : SCAN-ordered elevator scheduler with travel timing and door dwell.
// Revision : 1.0
// ============================================================================
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = c_DEF_NUM_FLOORS,
    parameter int FLOOR_W         = c_DEF_FLOOR_W,
    parameter int TICKS_PER_FLOOR = 100_000_000,
    parameter int DOOR_TICKS      = 200_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_FLOORS-1:0]     call_btn,
    output logic [c_FLOOR_CODE_W-1:0] floor_code,
    output logic [FLOOR_W-1:0]        cur_floor,
    output logic [NUM_FLOORS-1:0]     pending,
    output logic                      moving,
    output logic                      dir_up,
    output logic                      door_open
);

    localparam int c_TICK_MAX = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
    localparam int c_TIMER_W  = (c_TICK_MAX > 1) ? $clog2(c_TICK_MAX) : 1;
    localparam logic [c_TIMER_W-1:0] c_MOVE_LAST = c_TIMER_W'(TICKS_PER_FLOOR - 1);
    localparam logic [c_TIMER_W-1:0] c_DOOR_LAST = c_TIMER_W'(DOOR_TICKS - 1);

    state_t                      r_state;
    logic [c_TIMER_W-1:0]        r_timer;
    logic [FLOOR_W-1:0]          r_cur_floor;
    logic [NUM_FLOORS-1:0]       r_pending;
    logic                        r_dir_up;
    logic                        r_eval;
    logic                        r_moving;
    logic                        r_door_open;
    logic [c_FLOOR_CODE_W-1:0]   r_floor_code;

    state_t                      w_state_next;
    logic [c_TIMER_W-1:0]        w_timer_next;
    logic [FLOOR_W-1:0]          w_floor_next;
    logic                        w_dir_next;
    logic                        w_eval_next;
    logic                        w_step;
    logic [NUM_FLOORS-1:0]       w_set;
    logic [NUM_FLOORS-1:0]       w_clr;
    logic [NUM_FLOORS-1:0]       w_suppress;
    logic [NUM_FLOORS-1:0]       w_cur_onehot;
    logic [NUM_FLOORS-1:0]       w_pending_next;
    logic                        w_above;
    logic                        w_below;
    logic                        w_here;
    logic                        w_press_here;
    logic                        w_ahead;
    logic                        w_behind;

    call_sync_edge #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_call_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .call_btn (call_btn),
        .set      (w_set)
    );

    always_comb begin
        w_above      = 1'b0;
        w_below      = 1'b0;
        w_cur_onehot = '0;
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (j == int'(r_cur_floor)) w_cur_onehot[j] = 1'b1;
            if (r_pending[j] && (j > int'(r_cur_floor))) w_above = 1'b1;
            if (r_pending[j] && (j < int'(r_cur_floor))) w_below = 1'b1;
        end
    end

    assign w_here         = |(r_pending & w_cur_onehot);
    assign w_press_here   = |(w_set & w_cur_onehot);
    assign w_ahead        = r_dir_up ? w_above : w_below;
    assign w_behind       = r_dir_up ? w_below : w_above;
    // A re-press at the open floor only extends the dwell.
    assign w_suppress     = (r_state == DOOR) ? w_cur_onehot : '0;
    assign w_pending_next = (r_pending & ~w_clr) | (w_set & ~w_suppress);

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer + c_TIMER_W'(1);
        w_floor_next = r_cur_floor;
        w_dir_next   = r_dir_up;
        w_eval_next  = 1'b0;
        w_step       = 1'b0;
        w_clr        = '0;
        case (r_state)
            IDLE: begin
                w_timer_next = '0;
                if (w_here) begin
                    w_clr        = w_cur_onehot;
                    w_state_next = DOOR;
                end else if (w_above && (r_dir_up || !w_below)) begin
                    w_dir_next   = c_DIR_UP;
                    w_state_next = MOVE;
                end else if (w_below) begin
                    w_dir_next   = c_DIR_DOWN;
                    w_state_next = MOVE;
                end
            end
            MOVE: begin
                if (r_timer == c_MOVE_LAST) w_timer_next = '0;
                if (r_eval && w_here) begin
                    w_clr        = w_cur_onehot;
                    w_state_next = DOOR;
                    w_timer_next = '0;
                end else if (r_eval && !w_ahead && !w_behind) begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                end else begin
                    if (r_eval && !w_ahead) w_dir_next = ~r_dir_up;
                    // The evaluation cycle never steps, so a decision always sees the new floor.
                    if (!r_eval && (r_timer == c_MOVE_LAST)) begin
                        w_step       = 1'b1;
                        w_eval_next  = 1'b1;
                        w_floor_next = r_dir_up ? (r_cur_floor + FLOOR_W'(1))
                                                : (r_cur_floor - FLOOR_W'(1));
                    end
                end
            end
            DOOR: begin
                if (w_press_here) begin
                    w_timer_next = '0;
                end else if (r_timer == c_DOOR_LAST) begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_cur_floor  <= '0;
            r_pending    <= '0;
            r_dir_up     <= c_DIR_UP;
            r_eval       <= 1'b0;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
            r_floor_code <= '0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_cur_floor  <= w_floor_next;
            r_pending    <= w_pending_next;
            r_dir_up     <= w_dir_next;
            r_eval       <= w_eval_next;
            r_moving     <= (w_state_next == MOVE);
            r_door_open  <= (w_state_next == DOOR);
            r_floor_code <= c_FLOOR_CODE_W'(w_floor_next);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_step) begin
            assert (r_dir_up ? (int'(r_cur_floor) < NUM_FLOORS - 1) : (r_cur_floor != '0));
        end
    end

    assign floor_code = r_floor_code;
    assign cur_floor  = r_cur_floor;
    assign pending    = r_pending;
    assign moving     = r_moving;
    assign dir_up     = r_dir_up;
    assign door_open  = r_door_open;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_floor_request_scheduler
// Brief    : Directed self-checking bench for floor_request_scheduler.
// Revision : 1.0
// ============================================================================
module tb_floor_request_scheduler;

    localparam int c_NF = 10;
    localparam int c_FW = 4;

    logic              clk;
    logic              reset;
    logic [c_NF-1:0]   call_btn;
    logic [4:0]        floor_code;
    logic [c_FW-1:0]   cur_floor;
    logic [c_NF-1:0]   pending;
    logic              moving;
    logic              dir_up;
    logic              door_open;

    int n_cmp;
    int n_err;
    int door_rises;
    int move_rises;
    logic prev_door;
    logic prev_move;

    floor_request_scheduler #(
        .NUM_FLOORS      (c_NF),
        .FLOOR_W         (c_FW),
        .TICKS_PER_FLOOR (4),
        .DOOR_TICKS      (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .call_btn   (call_btn),
        .floor_code (floor_code),
        .cur_floor  (cur_floor),
        .pending    (pending),
        .moving     (moving),
        .dir_up     (dir_up),
        .door_open  (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        call_btn = '0;

        // Reset
        tick(2);
        reset = 1'b0;
        chk("rst_cur", 32'(cur_floor), 32'd0);
        chk("rst_code", 32'(floor_code), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_move", 32'(moving), 32'd0);
        chk("rst_door", 32'(door_open), 32'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);

        // Single trip 0 -> 3
        call_btn = 10'h008;
        tick(2);
        chk("t2_pend_early", 32'(pending), 32'h000);
        call_btn = '0;
        tick(1);
        chk("t2_pend", 32'(pending), 32'h008);
        chk("t2_idle", 32'(moving), 32'd0);
        tick(1);
        chk("t2_move", 32'(moving), 32'd1);
        chk("t2_cur0", 32'(cur_floor), 32'd0);
        tick(3);
        chk("t2_cur0b", 32'(cur_floor), 32'd0);
        tick(1);
        chk("t2_cur1", 32'(cur_floor), 32'd1);
        tick(4);
        chk("t2_cur2", 32'(cur_floor), 32'd2);
        tick(4);
        chk("t2_cur3", 32'(cur_floor), 32'd3);
        chk("t2_code3", 32'(floor_code), 32'd3);
        chk("t2_move3", 32'(moving), 32'd1);
        tick(1);
        chk("t2_door", 32'(door_open), 32'd1);
        chk("t2_nomove", 32'(moving), 32'd0);
        chk("t2_clr", 32'(pending), 32'd0);
        tick(2);
        chk("t2_door_last", 32'(door_open), 32'd1);
        tick(1);
        chk("t2_door_end", 32'(door_open), 32'd0);
        chk("t2_idle_end", 32'(moving), 32'd0);

        // SCAN: 3 -> 7 first, then reverse to 2
        call_btn = 10'h080;
        tick(2);
        call_btn = '0;
        tick(10);
        chk("t3_cur5", 32'(cur_floor), 32'd5);
        call_btn = 10'h004;
        tick(2);
        call_btn = '0;
        tick(2);
        chk("t3_cur6", 32'(cur_floor), 32'd6);
        chk("t3_pend2", 32'(pending), 32'h084);
        tick(4);
        chk("t3_cur7", 32'(cur_floor), 32'd7);
        tick(1);
        chk("t3_door7", 32'(door_open), 32'd1);
        chk("t3_pend_left", 32'(pending), 32'h004);
        chk("t3_dir_up", 32'(dir_up), 32'd1);
        tick(3);
        chk("t3_idle7", 32'(door_open | moving), 32'd0);
        tick(1);
        chk("t3_move_dn", 32'(moving), 32'd1);
        chk("t3_dir_dn", 32'(dir_up), 32'd0);
        chk("t3_cur7b", 32'(cur_floor), 32'd7);
        tick(4);
        chk("t3_cur6b", 32'(cur_floor), 32'd6);
        tick(16);
        chk("t3_cur2", 32'(cur_floor), 32'd2);
        chk("t3_code2", 32'(floor_code), 32'd2);
        tick(1);
        chk("t3_door2", 32'(door_open), 32'd1);
        chk("t3_pend_done", 32'(pending), 32'd0);
        tick(3);
        chk("t3_idle2", 32'(door_open | moving), 32'd0);

        // Go to floor 4, then call at the idle floor and extend the door
        call_btn = 10'h010;
        tick(2);
        call_btn = '0;
        tick(10);
        chk("t4_cur4", 32'(cur_floor), 32'd4);
        chk("t4_dir", 32'(dir_up), 32'd1);
        tick(1);
        chk("t4_arrive_door", 32'(door_open), 32'd1);
        tick(3);
        chk("t4_arrive_idle", 32'(door_open), 32'd0);
        tick(2);
        call_btn = 10'h010;
        tick(2);
        call_btn = '0;
        tick(1);
        chk("t4_pend_here", 32'(pending), 32'h010);
        chk("t4_door_pre", 32'(door_open), 32'd0);
        tick(1);
        chk("t4_door", 32'(door_open), 32'd1);
        chk("t4_nomove", 32'(moving), 32'd0);
        chk("t4_cur", 32'(cur_floor), 32'd4);
        chk("t4_pend_clr", 32'(pending), 32'd0);
        call_btn = 10'h010;
        tick(2);
        call_btn = '0;
        tick(1);
        chk("t4_door_ext", 32'(door_open), 32'd1);
        chk("t4_suppress", 32'(pending), 32'd0);
        tick(2);
        chk("t4_door_ext_last", 32'(door_open), 32'd1);
        tick(1);
        chk("t4_door_close", 32'(door_open), 32'd0);
        chk("t4_pend_end", 32'(pending), 32'd0);
        chk("t4_cur_end", 32'(cur_floor), 32'd4);

        // Held switch: one trip, one door cycle
        door_rises = 0;
        move_rises = 0;
        prev_door  = door_open;
        prev_move  = moving;
        call_btn = 10'h040;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (door_open && !prev_door) door_rises++;
            if (moving && !prev_move) move_rises++;
            prev_door = door_open;
            prev_move = moving;
        end
        chk("t5_door_once", 32'(door_rises), 32'd1);
        chk("t5_move_once", 32'(move_rises), 32'd1);
        chk("t5_cur6", 32'(cur_floor), 32'd6);
        chk("t5_pend_none", 32'(pending), 32'd0);
        call_btn = '0;
        tick(3);
        call_btn = 10'h040;
        tick(2);
        call_btn = '0;
        tick(1);
        chk("t5_repress", 32'(pending), 32'h040);
        tick(1);
        chk("t5_repress_door", 32'(door_open), 32'd1);
        tick(3);

        // Reset while travelling 2 -> 3 with a call at 8 outstanding
        call_btn = 10'h004;
        tick(2);
        call_btn = '0;
        tick(18);
        chk("t6_cur2", 32'(cur_floor), 32'd2);
        tick(1);
        chk("t6_door2", 32'(door_open), 32'd1);
        tick(3);
        call_btn = 10'h100;
        tick(2);
        call_btn = '0;
        tick(4);
        chk("t6_moving", 32'(moving), 32'd1);
        chk("t6_pend8", 32'(pending), 32'h100);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_cur", 32'(cur_floor), 32'd0);
        chk("t6_code", 32'(floor_code), 32'd0);
        chk("t6_pend", 32'(pending), 32'd0);
        chk("t6_move", 32'(moving), 32'd0);
        chk("t6_door", 32'(door_open), 32'd0);
        chk("t6_dir", 32'(dir_up), 32'd1);
        tick(5);
        chk("t6_stay_idle", 32'(moving), 32'd0);

        // Simultaneous presses latch together
        call_btn = 10'h222;
        tick(2);
        call_btn = '0;
        tick(1);
        chk("t7_pend_multi", 32'(pending), 32'h222);
        tick(1);
        chk("t7_move", 32'(moving), 32'd1);
        tick(4);
        chk("t7_cur1", 32'(cur_floor), 32'd1);
        tick(1);
        chk("t7_door1", 32'(door_open), 32'd1);
        chk("t7_pend_left", 32'(pending), 32'h220);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
- Controller that sits in front of the floor display path.
- Latches floor-call switch presses into a pending-request set.
- Schedules car movement with SCAN ordering: keep going in the current direction while requests remain ahead, then reverse.
- Sequences per-floor travel time and door dwell, and drives the 5-bit floor code that feeds the BCD-to-7-seg decoder and the time-multiplexed display.

Parameters:
- NUM_FLOORS, 10: number of floors (0..NUM_FLOORS-1).
- FLOOR_W, 4: width of the floor index.
- TICKS_PER_FLOOR, 100_000_000: clk cycles to travel one floor (1 s at 100 MHz).
- DOOR_TICKS, 200_000_000: clk cycles the door stays open.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- call_btn  in  NUM_FLOORS  raw floor-call switch levels; bit i = floor i; asynchronous to clk.
- floor_code  out  5  current floor, zero-extended; feeds the BCD decoder Q input.
- cur_floor  out  FLOOR_W  current floor index.
- pending  out  NUM_FLOORS  registered outstanding requests.
- moving  out  1  high while in MOVE.
- dir_up  out  1  1 = up, 0 = down; last committed direction.
- door_open  out  1  high while in DOOR.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, and overrides everything, including mid-move and mid-door.
- Reset values: state=IDLE, cur_floor=0, floor_code=0, pending=0, moving=0, door_open=0, dir_up=1, timer=0, synchroniser flops=0.
- Input path:
  - Each call_btn bit passes through a 2-FF synchroniser, then rising-edge detection (sync2 & ~sync3).
  - Pending bit i is set on the clk edge after the detected edge. An input rising before edge k is visible on pending after edge k+2.
  - A held switch produces exactly one request. A new request needs a release and a re-press.
- Pending update: pending_next = (pending & ~clr) | (set & ~suppress).
  - Set wins over clear for the same bit.
  - suppress = set bit equal to cur_floor while in DOOR (see below).
- Request aggregates are computed from registered pending only:
  - above = any pending[j] with j > cur_floor.
  - below = any pending[j] with j < cur_floor.
  - here = pending[cur_floor].
- States:
  - IDLE:
    - here: clear bit, load timer, go to DOOR.
    - else above && (dir_up || !below): dir_up=1, go to MOVE.
    - else below: dir_up=0, go to MOVE.
    - else stay in IDLE.
  - MOVE:
    - Timer counts 0..TICKS_PER_FLOOR-1.
    - At terminal count, cur_floor moves ±1 per dir_up and the timer resets.
    - The cycle after the step, evaluate the new floor:
      - here: clear bit, go to DOOR.
      - else request ahead in dir_up: continue MOVE.
      - else request behind: flip dir_up, continue MOVE.
      - else go to IDLE.
    - A request set on the same cycle as the evaluation is not seen; the car passes that floor.
  - DOOR:
    - Timer counts 0..DOOR_TICKS-1, then go to IDLE, which performs the next decision.
    - A detected press for cur_floor while in DOOR restarts the dwell timer to 0 and does not set pending.
- Boundaries:
  - cur_floor never goes below 0 or above NUM_FLOORS-1. Direction logic guarantees this; an out-of-range step is a design error and is covered by an assertion.
  - Simultaneous presses on many floors are all latched in the same cycle.
- Timer:
  - Width is ceil(log2(max(TICKS_PER_FLOOR, DOOR_TICKS))).
  - The timer is shared between MOVE and DOOR and is cleared on every state change.
- Output registering: all outputs are registered, so moving, door_open and floor_code change on the same edge as the state.

Decomposition:
- Package elevator_pkg:
  - state enum: IDLE, MOVE, DOOR.
  - DIR_UP / DIR_DOWN constants.
  - NUM_FLOORS and FLOOR_W defaults.
  - floor_code width constant (5).
- Sub-module call_sync_edge: NUM_FLOORS-wide 2-FF synchroniser plus edge detector, outputting a one-cycle set pulse vector.
- Timer, pending register and FSM stay in the top of the block.

Test Plan (TICKS_PER_FLOOR=4, DOOR_TICKS=3):
1. Assert reset for 2 cycles, then release -> cur_floor=0, floor_code=5'd0, pending=0, moving=0, door_open=0, dir_up=1.
2. From idle at floor 0, pulse call_btn[3] -> pending[3]=1 three edges later, moving=1, cur_floor steps 1,2,3 every 4 cycles, then door_open=1 for 3 cycles, pending[3]=0, back to IDLE.
3. Car moving up between 5 and 6 with pending[7] and pending[2] -> stops at 7 first, then dir_up=0, travels down and stops at 2; pending=0 at end.
4. Idle at floor 4, press call_btn[4] -> door_open=1, moving stays 0, cur_floor stays 4. A second press of floor 4 during DOOR extends door_open by a full 3 cycles and pending[4] stays 0.
5. Hold call_btn[6] high for 100 cycles -> exactly one trip to floor 6 and one door cycle. Release and re-press -> a new request is latched.
6. Assert reset while moving from 2 to 3 with pending[8] set -> next cycle cur_floor=0, pending=0, moving=0, state IDLE.
